// File: rtl/mult_hilo_sequencer.sv
// HI/LO register owner for the multi-cycle MIPS core: MT/MF accesses plus a
// 32-iteration radix-2 shift-add multiplier with sign correction and atomic commit.
module mult_hilo_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic [2:0]      cmd_op_i,
  input  logic [XLEN-1:0] cmd_a_i,
  input  logic [XLEN-1:0] cmd_b_i,
  input  logic            cancel_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            rd_valid_o,
  output logic [XLEN-1:0] rd_data_o,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  localparam int PW = 2 * XLEN;
  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

  localparam logic [2:0] OP_MULTU = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MTHI  = 3'd2;
  localparam logic [2:0] OP_MTLO  = 3'd3;
  localparam logic [2:0] OP_MFHI  = 3'd4;
  localparam logic [2:0] OP_MFLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_NEG  = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  state_e          state_q,   state_d;
  logic [PW-1:0]   mcand_q,   mcand_d;
  logic [PW-1:0]   prod_q,    prod_d;
  logic [XLEN-1:0] mplier_q,  mplier_d;
  logic [CW-1:0]   cnt_q,     cnt_d;
  logic            neg_q,     neg_d;
  logic            is_mult_q, is_mult_d;
  logic [XLEN-1:0] hi_q,      hi_d;
  logic [XLEN-1:0] lo_q,      lo_d;
  logic [XLEN-1:0] rd_data_q, rd_data_d;
  logic            rd_valid_q, rd_valid_d;
  logic            done_q,    done_d;

  // Two's-complement magnitude; the most negative value maps onto itself,
  // which is still correct when read as an unsigned XLEN-bit number.
  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v);
    if (v[XLEN-1]) begin
      magnitude = (~v) + {{(XLEN-1){1'b0}}, 1'b1};
    end else begin
      magnitude = v;
    end
  endfunction

  // Next-state and datapath update
  always_comb begin
    state_d    = state_q;
    mcand_d    = mcand_q;
    prod_d     = prod_q;
    mplier_d   = mplier_q;
    cnt_d      = cnt_q;
    neg_d      = neg_q;
    is_mult_d  = is_mult_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          case (cmd_op_i)
            OP_MULTU, OP_MULT: begin
              if (cmd_op_i == OP_MULT) begin
                mcand_d  = {{XLEN{1'b0}}, magnitude(cmd_a_i)};
                mplier_d = magnitude(cmd_b_i);
                neg_d    = cmd_a_i[XLEN-1] ^ cmd_b_i[XLEN-1];
              end else begin
                mcand_d  = {{XLEN{1'b0}}, cmd_a_i};
                mplier_d = cmd_b_i;
                neg_d    = 1'b0;
              end
              is_mult_d = (cmd_op_i == OP_MULT);
              prod_d    = '0;
              cnt_d     = '0;
              state_d   = ST_RUN;
            end
            OP_MTHI: hi_d = cmd_a_i;
            OP_MTLO: lo_d = cmd_a_i;
            OP_MFHI: begin
              rd_data_d  = hi_q;
              rd_valid_d = 1'b1;
            end
            OP_MFLO: begin
              rd_data_d  = lo_q;
              rd_valid_d = 1'b1;
            end
            default: state_d = ST_IDLE;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cancel_i) begin
          state_d = ST_IDLE;
        end else begin
          if (mplier_q[0]) begin
            prod_d = prod_q + mcand_q;
          end else begin
            prod_d = prod_q;
          end
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            state_d = is_mult_q ? ST_NEG : ST_WB;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_NEG: begin
        if (cancel_i) begin
          state_d = ST_IDLE;
        end else begin
          if (neg_q) begin
            prod_d = (~prod_q) + {{(PW-1){1'b0}}, 1'b1};
          end else begin
            prod_d = prod_q;
          end
          state_d = ST_WB;
        end
      end
      ST_WB: begin
        // A cancel arriving with the commit edge must still suppress the write.
        if (cancel_i) begin
          state_d = ST_IDLE;
        end else begin
          hi_d    = prod_q[PW-1:XLEN];
          lo_d    = prod_q[XLEN-1:0];
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q    <= ST_IDLE;
      mcand_q    <= '0;
      prod_q     <= '0;
      mplier_q   <= '0;
      cnt_q      <= '0;
      neg_q      <= 1'b0;
      is_mult_q  <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mcand_q    <= mcand_d;
      prod_q     <= prod_d;
      mplier_q   <= mplier_d;
      cnt_q      <= cnt_d;
      neg_q      <= neg_d;
      is_mult_q  <= is_mult_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
    end
  end

  assign busy_o      = (state_q != ST_IDLE);
  assign cmd_ready_o = (state_q == ST_IDLE);
  assign done_o      = done_q;
  assign rd_valid_o  = rd_valid_q;
  assign rd_data_o   = rd_data_q;
  assign hi_o        = hi_q;
  assign lo_o        = lo_q;

endmodule

// File: doc/mult_hilo_sequencer.md
# mult_hilo_sequencer

Sequencer and owner of the HI/LO register pair for the multi-cycle MIPS core. It accepts MULTU/MULT/MTHI/MTLO/MFHI/MFLO commands from the main controller FSM over a valid/ready handshake. It runs an internal radix-2 shift-add multiplier for 32 iterations and applies sign correction for MULT. It commits the 64-bit product to HI/LO atomically and interlocks HI/LO reads while a multiply is in flight. The controller stalls in its execute state until `cmd_ready` is high, and captures `rd_data` when `rd_valid` is high.

## Interface
- XLEN, 32: operand and HI/LO width; product is 2*XLEN. Only 32 is verified.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge)
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept; high only in IDLE
- cmd_op  in  3  0=MULTU, 1=MULT, 2=MTHI, 3=MTLO, 4=MFHI, 5=MFLO; 6/7 reserved (accepted, no effect)
- cmd_a  in  XLEN  rs value (multiplicand; data source for MTHI/MTLO)
- cmd_b  in  XLEN  rt value (multiplier)
- cancel  in  1  flush of the in-flight multiply (exception/redirect)
- busy  out  1  multiply in progress (state != IDLE)
- done  out  1  one-cycle pulse: HI/LO just committed by a multiply
- rd_valid  out  1  one-cycle pulse: rd_data holds the MFHI/MFLO result
- rd_data  out  XLEN  registered HI or LO value
- hi, lo  out  XLEN  architectural HI/LO (registered)

## Operation
- States: IDLE, RUN, NEG, WB.
- Accept occurs when cmd_valid && cmd_ready at a rising edge (E0). The command is captured at E0. Inputs are don't-care afterwards.
- **MTHI/MTLO:** HI (or LO) <= cmd_a at E0; the block stays in IDLE.
- **MFHI/MFLO:** rd_data <= HI (or LO) at E0; rd_valid = 1 for the cycle after E0; the block stays in IDLE.
- **MULTU at E0:**
  - mcand(64) <= {0, cmd_a}, mplier <= cmd_b, prod <= 0, cnt <= 0, neg_flag <= 0, state <= RUN.
- **MULT at E0:**
  - mcand <= |cmd_a| and mplier <= |cmd_b|, as XLEN-bit unsigned two's-complement magnitudes. The magnitude of 0x80000000 is 0x80000000.
  - neg_flag <= cmd_a[31] ^ cmd_b[31].
- **RUN, each edge:**
  - if mplier[0], prod <= prod + mcand (64-bit, no overflow is possible); mcand <= mcand << 1; mplier <= mplier >> 1; cnt <= cnt + 1.
  - On the 32nd RUN edge (cnt == 31): go to NEG if the op is MULT, else to WB.
- **NEG, one edge:** if neg_flag, prod <= ~prod + 1; go to WB. MULT always passes through NEG, so its latency is fixed.
- **WB, one edge:** {HI, LO} <= prod; done <= 1; state <= IDLE.
- **cancel:** while in RUN/NEG/WB with cancel = 1, the next edge forces IDLE. HI/LO stay unchanged and done stays 0. cancel is ignored in IDLE.
- Reserved ops are accepted as no-ops, with no rd_valid and no state change.

## Timing
- Reset (reset = 0 at an edge): state = IDLE, hi = lo = 0, rd_data = 0, done = 0, rd_valid = 0, busy = 0, cmd_ready = 1. Reset aborts any in-flight multiply.
- **MULTU:** accept at E0, RUN edges E1..E32, WB at E33. New HI/LO are visible and done = 1 in the cycle after E33. cmd_ready returns high in that same cycle.
- **MULT:** same sequence with NEG at E33 and WB at E34; done is high in the cycle after E34.
- busy is high from the cycle after E0 through the cycle containing the WB edge.
- cmd_ready = !busy. No command of any kind is accepted while a multiply is pending, which interlocks MFHI/MFLO against stale HI/LO.
- A command can be accepted in the same cycle that done is high (back-to-back). MFHI accepted then returns the newly committed HI.
- MTHI/MTLO: new value on hi/lo in the cycle after E0. Back-to-back MT/MF on consecutive cycles returns the newly written value.
- done and rd_valid are never high for more than one consecutive cycle unless a new command is accepted.
- cancel and the WB edge in the same cycle: cancel wins and HI/LO are not written.

## Test plan
- Reset behaviour: hold reset = 0 for 2 cycles mid-MULT (at RUN cnt = 10), then release. Required: state IDLE, hi = lo = 0, busy = 0, cmd_ready = 1.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF: HI = 0xFFFFFFFE, LO = 0x00000001. done appears exactly 34 cycles after the acceptance cycle, and busy is high for 33 cycles.
- MULT signed cases, done exactly 35 cycles after acceptance:
  - 0xFFFFFFFF × 0x00000002: HI = 0xFFFFFFFF, LO = 0xFFFFFFFE.
  - 0x80000000 × 0x80000000: HI = 0x40000000, LO = 0x00000000.
- MTHI 0x12345678 then MFHI, followed by MTLO 0xCAFEBABE then MFLO, all on consecutive cycles. Required: rd_valid pulses with rd_data = 0x12345678, then 0xCAFEBABE.
- Interlock:
  - Issue MULTU 7 × 6, then immediately hold MFLO valid. Required: cmd_ready stays low for 33 cycles.
  - MFLO is accepted in the done cycle and returns rd_data = 0x0000002A.
- Cancel:
  - Preset HI/LO = 0x11111111/0x22222222 and start MULT 3 × 5.
  - Pulse cancel at RUN cnt = 20. Required: IDLE next cycle, done never asserts, HI/LO unchanged.
  - A cancel pulse coincident with the WB edge likewise leaves HI/LO unchanged.
